// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: captures PC, performs a req/ack memory read, latches IR, flags illop/xadr.
// Optional bus timeout in REQ is enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_IR       = 32'h0000_0000,
   parameter int          TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic        fetch_start,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] ir,
   output logic [31:0] pc_plus4,
   output logic        fetch_done,
   output logic        busy,
   output logic        illop,
   output logic        xadr
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_FAULT} state_t;

   state_t state, state_nx;
   logic   cause_illop, cause_illop_nx;
   logic   timeout;
   logic   op_legal;

   function automatic logic is_legal(input logic [5:0] op);
      case (op)
         6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
         6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B: return 1'b1;
         default:                                         return 1'b0;
      endcase
   endfunction

   assign op_legal = is_legal(mem_rdata[31:26]);

`ifdef FETCH_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] req_cnt;

   // Counter idles at zero outside REQ, so it is already clear on entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)               req_cnt <= '0;
      else if (state != S_REQ) req_cnt <= '0;
      else if (!mem_ack)       req_cnt <= req_cnt + 1'b1;
   end

   assign timeout = (req_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         cause_illop <= 1'b0;
      end else begin
         state       <= state_nx;
         cause_illop <= cause_illop_nx;
      end
   end

   // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      state_nx       = state;
      cause_illop_nx = cause_illop;
      case (state)
         S_IDLE: begin
            if (fetch_start) begin
               if (pc[1:0] != 2'b00) begin
                  state_nx       = S_FAULT;
                  cause_illop_nx = 1'b0;
               end else begin
                  state_nx = S_REQ;
               end
            end
         end
         S_REQ: begin
            if (mem_ack) begin
               if (op_legal) begin
                  state_nx = S_DONE;
               end else begin
                  state_nx       = S_FAULT;
                  cause_illop_nx = 1'b1;
               end
            end else if (timeout) begin
               state_nx       = S_FAULT;
               cause_illop_nx = 1'b0;
            end
         end
         S_DONE:  state_nx = S_IDLE;
         S_FAULT: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_addr <= 32'h0000_0000;
         pc_plus4 <= 32'h0000_0004;
         ir       <= RESET_IR;
      end else begin
         if (state == S_IDLE && fetch_start) begin
            mem_addr <= pc;
            pc_plus4 <= pc + 32'd4;
         end
         if (state == S_REQ && mem_ack) begin
            ir <= op_legal ? mem_rdata : RESET_IR;
         end
      end
   end

   assign mem_req    = (state == S_REQ);
   assign busy       = (state != S_IDLE);
   assign fetch_done = (state == S_DONE);
   assign illop      = (state == S_FAULT) &&  cause_illop;
   assign xadr       = (state == S_FAULT) && !cause_illop;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed cases plus randomized fetches vs. a transaction model.
// Timeout expectations follow FETCH_TIMEOUT_EN when the bench is built with it.
module tb_instr_fetch_unit;

   localparam logic [31:0] RESET_IR = 32'h0000_0000;
   localparam int          TO_CYC   = 16;
`ifdef FETCH_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic        fetch_start;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] ir;
   logic [31:0] pc_plus4;
   logic        fetch_done;
   logic        busy;
   logic        illop;
   logic        xadr;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_ir;
   logic [5:0]  legal_ops[$] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
                                 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};

   instr_fetch_unit #(.RESET_IR(RESET_IR), .TIMEOUT_CYCLES(TO_CYC)) dut (
      .clk        (clk),
      .reset      (reset),
      .pc         (pc),
      .fetch_start(fetch_start),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .ir         (ir),
      .pc_plus4   (pc_plus4),
      .fetch_done (fetch_done),
      .busy       (busy),
      .illop      (illop),
      .xadr       (xadr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit op_is_legal(input logic [5:0] op);
      foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   // One complete fetch transaction; entered and left at a negedge with the unit idle.
   task automatic fetch(input logic [31:0] a, input int delay, input logic [31:0] rd);
      bit aligned   = (a[1:0] == 2'b00);
      bit timed_out = TO_EN && (delay >= TO_CYC);
      int n_wait    = timed_out ? TO_CYC : delay;
      check("idle_before", busy, 0);
      pc = a; fetch_start = 1'b1; mem_ack = 1'b0;
      @(negedge clk);
      fetch_start = 1'($urandom_range(0, 1));
      pc = $urandom;
      check("mem_addr_cap", mem_addr, a);
      check("pc_plus4", pc_plus4, a + 32'd4);
      if (!aligned) begin
         check("mis_mem_req", mem_req, 0);
         check("mis_pulses", {fetch_done, illop, xadr}, 3'b001);
         fetch_start = 1'b0;
         @(negedge clk);
         check("mis_after", {busy, fetch_done, illop, xadr, mem_req}, 0);
         check("mis_ir", ir, exp_ir);
         return;
      end
      for (int i = 0; i < n_wait; i++) begin
         check("wait_req", mem_req, 1);
         check("wait_addr", mem_addr, a);
         check("wait_pulses", {fetch_done, illop, xadr}, 0);
         mem_ack = 1'b0; mem_rdata = $urandom;
         @(negedge clk);
         fetch_start = 1'($urandom_range(0, 1));
      end
      if (timed_out) begin
         check("to_pulses", {mem_req, fetch_done, illop, xadr}, 4'b0001);
         check("to_ir", ir, exp_ir);
         fetch_start = 1'b0;
         @(negedge clk);
         check("to_after", {busy, fetch_done, illop, xadr}, 0);
         return;
      end
      check("ack_req", mem_req, 1);
      check("ack_addr", mem_addr, a);
      mem_ack = 1'b1; mem_rdata = rd;
      @(negedge clk);
      mem_ack = 1'b0; fetch_start = 1'b0; mem_rdata = $urandom;
      if (op_is_legal(rd[31:26])) begin
         exp_ir = rd;
         check("done_pulses", {fetch_done, illop, xadr}, 3'b100);
      end else begin
         exp_ir = RESET_IR;
         check("illop_pulses", {fetch_done, illop, xadr}, 3'b010);
      end
      check("ir_latched", ir, exp_ir);
      check("req_dropped", mem_req, 0);
      @(negedge clk);
      check("end_idle", {busy, fetch_done, illop, xadr}, 0);
      check("ir_held", ir, exp_ir);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         fetch_start = 1'b0;
         mem_ack = 1'($urandom_range(0, 1));
         mem_rdata = $urandom;
         @(negedge clk);
         check("idle_quiet", {busy, mem_req, fetch_done, illop, xadr}, 0);
         check("idle_ir", ir, exp_ir);
      end
      mem_ack = 1'b0;
   endtask

   task automatic reset_mid_req();
      pc = 32'h0000_0040; fetch_start = 1'b1; mem_ack = 1'b0;
      @(negedge clk);
      fetch_start = 1'b0;
      check("rst_in_req", mem_req, 1);
      #2 reset = 1'b1;
      #1;
      check("rst_req_async", {mem_req, busy}, 0);
      check("rst_ir", ir, RESET_IR);
      check("rst_addr", mem_addr, 32'h0);
      check("rst_pc4", pc_plus4, 32'h4);
      #1 reset = 1'b0;
      exp_ir = RESET_IR;
      mem_ack = 1'b1; mem_rdata = 32'h8C08_0004;
      @(negedge clk);
      mem_ack = 1'b0;
      check("rst_ack_ignored", {busy, mem_req, fetch_done, illop, xadr}, 0);
      check("rst_ir_kept", ir, exp_ir);
      @(negedge clk);
      check("rst_no_pulse", {busy, fetch_done, illop, xadr}, 0);
   endtask

   initial begin
      logic [31:0] a, rd;
      int          d;
      exp_ir = RESET_IR;
      reset = 1'b1; pc = '0; fetch_start = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
      #1;
      check("reset_ir", ir, RESET_IR);
      check("reset_pc4", pc_plus4, 32'h4);
      check("reset_addr", mem_addr, 32'h0);
      check("reset_outs", {busy, mem_req, fetch_done, illop, xadr}, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      idle_cycles(2);

      fetch(32'h0000_0010, 0, 32'h8C08_0004);
      check("t1_ir", ir, 32'h8C08_0004);
      fetch(32'h0000_0006, 0, 32'h0);
      fetch(32'h0000_0020, 5, 32'h2001_0005);
      fetch(32'h0000_0100, 0, 32'hFC00_0000);
      check("t4_ir", ir, RESET_IR);
      fetch(32'hFFFF_FFFC, 1, 32'hAC00_0000);
      fetch(32'h0000_0201, 0, 32'h0);
      fetch(32'h0000_0204, 2, 32'h0400_0000);
      idle_cycles(3);
      reset_mid_req();
      fetch(32'h0000_0300, TO_CYC, 32'h8C00_0000);
      fetch(32'h0000_0304, TO_CYC - 1, 32'h8C00_1111);
      fetch(32'h0000_0308, TO_CYC + 4, 32'h0800_0000);

      for (int n = 0; n < 150; n++) begin
         a = $urandom;
         if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
         rd = $urandom;
         if ($urandom_range(0, 9) < 7) rd[31:26] = legal_ops[$urandom_range(0, 13)];
         d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(12, 20)) : int'($urandom_range(0, 4));
         fetch(a, d, rd);
         if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
